// File: rtl/rfft_4pt_engine.sv
// In-place radix-2 butterfly engine over four sample banks (lane A = banks 0/1, lane B = banks 2/3).
// Load a frame, run N passes of A' = (A+W*B)/2, B' = (A-W*B)/2, then stream the frame back out.
module rfft_4pt_engine #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_BIT = 6,
    parameter int unsigned PASS_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DATA_W-1:0]   in_data,
    input  logic                  start,
    input  logic [PASS_W-1:0]     num_pass,
    input  logic                  bypass_en,
    output logic [ADDR_BIT-1:0]   tw_addr,
    input  logic [DATA_W-1:0]     tw_r,
    input  logic [DATA_W-1:0]     tw_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DATA_W-1:0]   out_data,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned DEPTH = 1 << ADDR_BIT;
    localparam int unsigned PW    = 2 * DATA_W;
    localparam int unsigned XW    = DATA_W + 3;
    localparam logic [ADDR_BIT-1:0] LAST = ADDR_BIT'(DEPTH - 1);

    typedef enum logic [2:0] {StLoad, StArmed, StCompute, StDrain, StUnload} state_e;

    state_e                state_q, state_d;
    logic [ADDR_BIT-1:0]   wr_ptr_q, wr_ptr_d, k_q, k_d, rd_ptr_q, rd_ptr_d, xfer_q, xfer_d;
    logic [PASS_W-1:0]     pass_q, pass_d;
    logic                  byp_q, byp_d, fetch_done_q, fetch_done_d;
    logic [1:0]            drain_q, drain_d;
    logic                  in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic                  v1_q, v1_d, v2_q, v2_d;
    logic [ADDR_BIT-1:0]   a1_q, a1_d, a2_q, a2_d;
    logic signed [PW-1:0]  p_rr_q, p_rr_d, p_ii_q, p_ii_d, p_ri_q, p_ri_d, p_ir_q, p_ir_d;
    logic [2*DATA_W-1:0]   a_q, a_d, b_q, b_d;

    logic [DATA_W-1:0]     mem [4][DEPTH];
    logic [4*DATA_W-1:0]   rd_q;
    logic                  rd_en, wr_en;
    logic [ADDR_BIT-1:0]   rd_addr, wr_addr;
    logic [4*DATA_W-1:0]   wr_word, bf_word;

    logic signed [PW-1:0]     br_x, bi_x, wr_x, wi_x;
    logic signed [PW:0]       tr_sum, ti_sum;
    logic signed [DATA_W+1:0] t_r, t_i;
    logic signed [XW-1:0]     ar_x, ai_x, tr_x, ti_x, ar_n, ai_n, br_n, bi_n;

    function automatic logic [DATA_W-1:0] sat(input logic signed [XW-1:0] x);
        logic [XW-DATA_W:0] top;
        top = x[XW-1:DATA_W-1];
        if ((&top) || !(|top)) begin
            return x[DATA_W-1:0];
        end else if (x[XW-1]) begin
            return {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end
    endfunction

    // Cycle 1: RAM data and twiddle are both valid; register the four partial products.
    always_comb begin
        br_x   = PW'($signed(rd_q[2*DATA_W +: DATA_W]));
        bi_x   = PW'($signed(rd_q[3*DATA_W +: DATA_W]));
        wr_x   = PW'($signed(tw_r));
        wi_x   = PW'($signed(tw_i));
        p_rr_d = br_x * wr_x;
        p_ii_d = bi_x * wi_x;
        p_ri_d = br_x * wi_x;
        p_ir_d = bi_x * wr_x;
        a_d    = rd_q[2*DATA_W-1:0];
        b_d    = rd_q[4*DATA_W-1:2*DATA_W];
        v1_d   = (state_q == StCompute);
        a1_d   = k_q;
        v2_d   = v1_q;
        a2_d   = a1_q;
    end

    // Cycle 2: twiddle scale, halve both outputs (floor) and saturate.
    always_comb begin
        tr_sum = (PW+1)'(p_rr_q) - (PW+1)'(p_ii_q);
        ti_sum = (PW+1)'(p_ri_q) + (PW+1)'(p_ir_q);
        t_r    = (DATA_W+2)'(tr_sum >>> (DATA_W-1));
        t_i    = (DATA_W+2)'(ti_sum >>> (DATA_W-1));
        ar_x   = XW'($signed(a_q[DATA_W-1:0]));
        ai_x   = XW'($signed(a_q[2*DATA_W-1:DATA_W]));
        tr_x   = XW'(t_r);
        ti_x   = XW'(t_i);
        ar_n   = (ar_x + tr_x) >>> 1;
        ai_n   = (ai_x + ti_x) >>> 1;
        br_n   = (ar_x - tr_x) >>> 1;
        bi_n   = (ai_x - ti_x) >>> 1;
        if (byp_q) begin
            bf_word = {b_q, a_q};
        end else begin
            bf_word = {sat(bi_n), sat(br_n), sat(ai_n), sat(ar_n)};
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        k_d          = k_q;
        pass_d       = pass_q;
        byp_d        = byp_q;
        drain_d      = drain_q;
        rd_ptr_d     = rd_ptr_q;
        xfer_d       = xfer_q;
        fetch_done_d = fetch_done_q;
        out_valid_d  = out_valid_q;
        in_ready_d   = in_ready_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = k_q;
        wr_en        = 1'b0;
        wr_addr      = a2_q;
        wr_word      = bf_word;
        unique case (state_q)
            StLoad: begin
                if (in_valid && in_ready_q) begin
                    wr_en    = 1'b1;
                    wr_addr  = wr_ptr_q;
                    wr_word  = in_data;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LAST) begin
                        state_d    = StArmed;
                        in_ready_d = 1'b0;
                    end
                end
            end
            StArmed: begin
                if (start) begin
                    pass_d  = num_pass;
                    byp_d   = bypass_en;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = (num_pass == '0) ? StUnload : StCompute;
                end
            end
            StCompute: begin
                rd_en = 1'b1;
                k_d   = k_q + 1'b1;
                if (k_q == LAST) begin
                    pass_d = pass_q - 1'b1;
                    if (pass_q == PASS_W'(1)) begin
                        state_d = StDrain;
                        drain_d = '0;
                    end
                end
            end
            StDrain: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == 2'd2) begin
                    state_d = StUnload;
                end
            end
            StUnload: begin
                // Fetch the next word whenever the output register is empty or being taken.
                rd_addr = rd_ptr_q;
                rd_en   = !fetch_done_q && (!out_valid_q || out_ready);
                if (rd_en) begin
                    rd_ptr_d    = rd_ptr_q + 1'b1;
                    out_valid_d = 1'b1;
                    if (rd_ptr_q == LAST) begin
                        fetch_done_d = 1'b1;
                    end
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (out_valid_q && out_ready) begin
                    xfer_d = xfer_q + 1'b1;
                    if (xfer_q == LAST) begin
                        state_d      = StLoad;
                        in_ready_d   = 1'b1;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        fetch_done_d = 1'b0;
                        out_valid_d  = 1'b0;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
        if (v2_q) begin
            wr_en   = 1'b1;
            wr_addr = a2_q;
            wr_word = bf_word;
        end
        if (rst) begin
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                mem[b][wr_addr] <= wr_word[b*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= {mem[3][rd_addr], mem[2][rd_addr], mem[1][rd_addr], mem[0][rd_addr]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StLoad;
            wr_ptr_q     <= '0;
            k_q          <= '0;
            pass_q       <= '0;
            byp_q        <= 1'b0;
            drain_q      <= '0;
            rd_ptr_q     <= '0;
            xfer_q       <= '0;
            fetch_done_q <= 1'b0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            a1_q         <= '0;
            a2_q         <= '0;
            p_rr_q       <= '0;
            p_ii_q       <= '0;
            p_ri_q       <= '0;
            p_ir_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            k_q          <= k_d;
            pass_q       <= pass_d;
            byp_q        <= byp_d;
            drain_q      <= drain_d;
            rd_ptr_q     <= rd_ptr_d;
            xfer_q       <= xfer_d;
            fetch_done_q <= fetch_done_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            a1_q         <= a1_d;
            a2_q         <= a2_d;
            p_rr_q       <= p_rr_d;
            p_ii_q       <= p_ii_d;
            p_ri_q       <= p_ri_d;
            p_ir_q       <= p_ir_d;
            a_q          <= a_d;
            b_q          <= b_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = rd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tw_addr   = k_q;

endmodule

// File: tb/tb_rfft_4pt_engine.sv
// Scoreboard bench for rfft_4pt_engine: expected frames are queued at start, a monitor pops them on
// every unload transfer; a twiddle ROM and an arithmetic reference model live in the bench.
module tb_rfft_4pt_engine;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, start, bypass_en, out_valid, out_ready, busy, done;
    logic [63:0] in_data, out_data;
    logic [3:0]  num_pass;
    logic [5:0]  tw_addr;
    logic [15:0] tw_r, tw_i;

    int checks = 0;
    int errors = 0;
    int m_ar[DEPTH], m_ai[DEPTH], m_br[DEPTH], m_bi[DEPTH];
    int rom_r[DEPTH], rom_i[DEPTH];
    logic [63:0] exp_q[$];
    bit rand_ready = 1'b0;

    always #5 clk = ~clk;

    rfft_4pt_engine #(.DATA_W(16), .ADDR_BIT(6), .PASS_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .start     (start),
        .num_pass  (num_pass),
        .bypass_en (bypass_en),
        .tw_addr   (tw_addr),
        .tw_r      (tw_r),
        .tw_i      (tw_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    function automatic int sat16(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return int'(x);
    endfunction

    function automatic logic [63:0] pack(input int ar, input int ai, input int br, input int bi);
        return {16'(bi), 16'(br), 16'(ai), 16'(ar)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: each pass applies the butterfly to every address with plain integer arithmetic.
    task automatic model(input int np, input bit byp);
        longint tr, ti;
        int nar, nai, nbr, nbi;
        if (byp) return;
        for (int p = 0; p < np; p++) begin
            for (int k = 0; k < DEPTH; k++) begin
                tr  = (longint'(m_br[k]) * rom_r[k] - longint'(m_bi[k]) * rom_i[k]) >>> 15;
                ti  = (longint'(m_br[k]) * rom_i[k] + longint'(m_bi[k]) * rom_r[k]) >>> 15;
                nar = sat16((m_ar[k] + tr) >>> 1);
                nai = sat16((m_ai[k] + ti) >>> 1);
                nbr = sat16((m_ar[k] - tr) >>> 1);
                nbi = sat16((m_ai[k] - ti) >>> 1);
                m_ar[k] = nar; m_ai[k] = nai; m_br[k] = nbr; m_bi[k] = nbi;
            end
        end
    endtask

    task automatic fill_const(input int ar, input int ai, input int br, input int bi,
                              input int wr, input int wi);
        for (int i = 0; i < DEPTH; i++) begin
            m_ar[i] = ar; m_ai[i] = ai; m_br[i] = br; m_bi[i] = bi;
            rom_r[i] = wr; rom_i[i] = wi;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            m_ar[i] = $urandom_range(0, 65535) - 32768;
            m_ai[i] = $urandom_range(0, 65535) - 32768;
            m_br[i] = $urandom_range(0, 65535) - 32768;
            m_bi[i] = $urandom_range(0, 65535) - 32768;
            rom_r[i] = $urandom_range(0, 65535) - 32768;
            rom_i[i] = $urandom_range(0, 65535) - 32768;
        end
    endtask

    task automatic load_mem();
        int n;
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) begin
            n = 0;
            in_data  = pack(m_ar[i], m_ai[i], m_br[i], m_bi[i]);
            in_valid = 1'b1;
            @(negedge clk);
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL load_timeout: word %0d in_ready=%b required 1", i, in_ready);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic run(input int np, input bit byp, input bit use_const, input logic [63:0] cexp);
        int n;
        int budget;
        if (use_const) begin
            repeat (DEPTH) exp_q.push_back(cexp);
        end else begin
            model(np, byp);
            for (int i = 0; i < DEPTH; i++) exp_q.push_back(pack(m_ar[i], m_ai[i], m_br[i], m_bi[i]));
        end
        budget = DEPTH * (np + 2) * 4 + 100;
        @(posedge clk); #1;
        num_pass  = 4'(np);
        bypass_en = byp;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        num_pass  = 4'($urandom);
        bypass_en = ~byp;
        n = 0;
        @(negedge clk);
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
        end
        check("busy_at_done", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("done_single_pulse", {63'd0, done}, 64'd0);
        check("busy_after_done", {63'd0, busy}, 64'd0);
        check("in_ready_after_done", {63'd0, in_ready}, 64'd1);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Twiddle ROM: data for the address seen in one cycle is presented in the next.
    initial begin
        logic [5:0] a;
        tw_r = '0;
        tw_i = '0;
        forever begin
            @(negedge clk);
            a = tw_addr;
            @(posedge clk); #1;
            tw_r = 16'(rom_r[a]);
            tw_i = 16'(rom_i[a]);
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        logic [63:0] e, prev_data;
        bit          prev_stall;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!(out_valid === 1'b1 && out_data === prev_data)) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h",
                                 out_valid, out_data, prev_data);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got %h with no word expected", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e) begin
                            errors++;
                            $display("FAIL unload_word: got %h expected %h", out_data, e);
                        end
                        if (exp_q.size() == 0) check("in_ready_last_xfer", {63'd0, in_ready}, 64'd0);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; start = 1'b0; num_pass = '0; bypass_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_out_data", out_data, 64'd0);
        check("reset_tw_addr", {58'd0, tw_addr}, 64'd0);

        // start must be ignored while loading
        @(posedge clk); #1;
        start = 1'b1; num_pass = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("start_ignored_busy", {63'd0, busy}, 64'd0);
        check("start_ignored_in_ready", {63'd0, in_ready}, 64'd1);

        // Pass-through with zero passes; stray in_valid in ARMED must not write.
        for (int i = 0; i < DEPTH; i++) begin
            m_ar[i] = i; m_ai[i] = i + 1; m_br[i] = i + 2; m_bi[i] = i + 3;
        end
        load_mem();
        @(negedge clk);
        check("armed_in_ready", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom};
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        run(0, 1'b0, 1'b0, '0);

        fill_const(100, 0, 200, 0, 16'h4000, 0);
        load_mem();
        run(1, 1'b0, 1'b1, {16'd0, 16'd0, 16'd0, 16'd100});
        load_mem();
        run(1, 1'b1, 1'b1, {16'd0, 16'd200, 16'd0, 16'd100});

        fill_const(32767, 0, -32768, -32768, -32768, 32767);
        load_mem();
        run(1, 1'b0, 1'b1, {16'hFFFF, 16'hC000, 16'h0000, 16'h7FFF});

        rand_ready = 1'b1;
        fill_random();
        load_mem();
        run(3, 1'b0, 1'b0, '0);
        fill_random();
        load_mem();
        run(2, 1'b1, 1'b0, '0);
        fill_random();
        load_mem();
        run(0, 1'b0, 1'b0, '0);

        // Abort mid-compute at k=20 of the first pass, then a fresh frame must come out right.
        fill_random();
        load_mem();
        @(posedge clk); #1;
        num_pass = 4'd2; bypass_en = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(busy && tw_addr == 6'd20) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_k20", {63'd0, (busy && tw_addr == 6'd20)}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_tw_addr", {58'd0, tw_addr}, 64'd0);
        fill_random();
        load_mem();
        run(1, 1'b0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
